// File: rtl/vn_lut_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vn_lut_pkg
// Description : Shared constants and load-FSM state encoding for the
//               symmetric variable-node IB-LUT rank (read and write paths).
// Revision    : 1.0 - initial release
// ============================================================================
package vn_lut_pkg;

  // LUT entries per load pass, one per page address
  localparam int PAGE_NUM = 32;
  // Page address width
  localparam int ADDR_W   = $clog2(PAGE_NUM);
  // LUT entry width
  localparam int QUAN_W   = 3;

  // Loader state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

endpackage : vn_lut_pkg
`default_nettype wire

// File: rtl/sym_vn_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : sym_vn_lut_loader
// Description : Write-side page loader for the symmetric 2-input VN IB-LUT
//               rank. Accepts 3-bit entries over valid/ready and writes them
//               to page addresses 0..PAGE_NUM-1 through two duplicated write
//               ports, then pulses load_done for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_vn_lut_loader
  import vn_lut_pkg::*;
(
  input  logic              write_clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic              lut_word_valid,
  input  logic [QUAN_W-1:0] lut_word,
  output logic              lut_word_ready,
  output logic [QUAN_W-1:0] lut_in_bank0_replicate_0,
  output logic [ADDR_W-1:0] page_write_addr_replicate_0,
  output logic [QUAN_W-1:0] lut_in_bank0_replicate_1,
  output logic [ADDR_W-1:0] page_write_addr_replicate_1,
  output logic              we,
  output logic              load_busy,
  output logic              load_done
);

  localparam logic [ADDR_W-1:0] LAST_PAGE = ADDR_W'(PAGE_NUM - 1);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] page_q,  page_d;
  logic              we_q,    we_d;

  // Replica write ports are duplicated purely for fanout towards the two
  // halves of the rank; the keep attribute stops synthesis from merging them.
  (* keep = "true" *) logic [QUAN_W-1:0] data_rep0_q;
  (* keep = "true" *) logic [ADDR_W-1:0] addr_rep0_q;
  (* keep = "true" *) logic [QUAN_W-1:0] data_rep1_q;
  (* keep = "true" *) logic [ADDR_W-1:0] addr_rep1_q;
  logic [QUAN_W-1:0] data_rep0_d, data_rep1_d;
  logic [ADDR_W-1:0] addr_rep0_d, addr_rep1_d;

  logic xfer;
  logic last_page;

  assign xfer      = lut_word_valid & lut_word_ready;
  assign last_page = (page_q == LAST_PAGE);

  // State register plus write-side datapath registers
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      page_q      <= '0;
      we_q        <= 1'b0;
      data_rep0_q <= '0;
      addr_rep0_q <= '0;
      data_rep1_q <= '0;
      addr_rep1_q <= '0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      we_q        <= we_d;
      data_rep0_q <= data_rep0_d;
      addr_rep0_q <= addr_rep0_d;
      data_rep1_q <= data_rep1_d;
      addr_rep1_q <= addr_rep1_d;
    end
  end

  // Next-state logic: start only honoured in IDLE, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start)         state_d = LOAD;
      LOAD:    if (xfer && last_page)  state_d = DONE;
      DONE:                            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    lut_word_ready = 1'b0;
    load_busy      = 1'b0;
    load_done      = 1'b0;
    case (state_q)
      LOAD: begin
        lut_word_ready = 1'b1;
        load_busy      = 1'b1;
      end
      DONE: begin
        load_busy      = 1'b1;
        load_done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Page counter and write-port next values; the counter parks on the last
  // page rather than wrapping, and the ports hold their value between writes
  always_comb begin
    page_d      = page_q;
    we_d        = xfer;
    data_rep0_d = data_rep0_q;
    addr_rep0_d = addr_rep0_q;
    data_rep1_d = data_rep1_q;
    addr_rep1_d = addr_rep1_q;

    if (state_q == IDLE && load_start) begin
      page_d = '0;
    end else if (xfer && !last_page) begin
      page_d = page_q + ADDR_W'(1);
    end

    if (xfer) begin
      data_rep0_d = lut_word;
      addr_rep0_d = page_q;
      data_rep1_d = lut_word;
      addr_rep1_d = page_q;
    end
  end

  assign we                          = we_q;
  assign lut_in_bank0_replicate_0    = data_rep0_q;
  assign page_write_addr_replicate_0 = addr_rep0_q;
  assign lut_in_bank0_replicate_1    = data_rep1_q;
  assign page_write_addr_replicate_1 = addr_rep1_q;

endmodule : sym_vn_lut_loader
`default_nettype wire

// File: tb/tb_sym_vn_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sym_vn_lut_loader
// Description : Directed self-checking bench for sym_vn_lut_loader. Inputs are
//               driven on the falling edge; outputs are checked on the next
//               falling edge, i.e. half a cycle after the DUT's active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sym_vn_lut_loader;

  logic       write_clk = 1'b0;
  logic       rstn;
  logic       load_start;
  logic       lut_word_valid;
  logic [2:0] lut_word;
  logic       lut_word_ready;
  logic [2:0] data0, data1;
  logic [4:0] addr0, addr1;
  logic       we;
  logic       load_busy;
  logic       load_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 write_clk = ~write_clk;

  sym_vn_lut_loader dut (
    .write_clk                   (write_clk),
    .rstn                        (rstn),
    .load_start                  (load_start),
    .lut_word_valid              (lut_word_valid),
    .lut_word                    (lut_word),
    .lut_word_ready              (lut_word_ready),
    .lut_in_bank0_replicate_0    (data0),
    .page_write_addr_replicate_0 (addr0),
    .lut_in_bank0_replicate_1    (data1),
    .page_write_addr_replicate_1 (addr1),
    .we                          (we),
    .load_busy                   (load_busy),
    .load_done                   (load_done)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive inputs for one cycle, let the DUT clock them, return at the next falling edge
  task automatic cycle(input logic v, input logic [2:0] w, input logic s);
    lut_word_valid = v;
    lut_word       = w;
    load_start     = s;
    @(posedge write_clk);
    @(negedge write_clk);
  endtask

  // One accepted entry for a given page: write visible one cycle later on both replicas
  task automatic xfer(input int page, input logic [2:0] w, input logic s);
    cycle(1'b1, w, s);
    check_eq("xfer_we",    we,    1);
    check_eq("xfer_addr0", addr0, page);
    check_eq("xfer_addr1", addr1, page);
    check_eq("xfer_data0", data0, w);
    check_eq("xfer_data1", data1, w);
    check_eq("xfer_done",  load_done,      (page == 31) ? 1 : 0);
    check_eq("xfer_ready", lut_word_ready, (page == 31) ? 0 : 1);
    check_eq("xfer_busy",  load_busy,      1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, lut_word_ready, 0);
    check_eq({tag, "_busy"},  load_busy,      0);
    check_eq({tag, "_done"},  load_done,      0);
    check_eq({tag, "_we"},    we,             0);
  endtask

  // Issue a start from IDLE and confirm LOAD is entered with no write
  task automatic start_pass(input string tag);
    cycle(1'b0, 3'd0, 1'b1);
    check_eq({tag, "_ready"}, lut_word_ready, 1);
    check_eq({tag, "_busy"},  load_busy,      1);
    check_eq({tag, "_we"},    we,             0);
  endtask

  logic [2:0] rnd_words [64];

  initial begin
    int         page;
    int         idx;
    logic [2:0] last_w;
    logic [2:0] w;

    rstn           = 1'b0;
    load_start     = 1'b0;
    lut_word_valid = 1'b0;
    lut_word       = 3'd0;

    // ---- Reset state ----
    @(negedge write_clk);
    @(negedge write_clk);
    check_eq("rst_data0", data0, 0);
    check_eq("rst_addr0", addr0, 0);
    check_eq("rst_data1", data1, 0);
    check_eq("rst_addr1", addr1, 0);
    check_idle("rst");
    rstn = 1'b1;
    cycle(1'b0, 3'd0, 1'b0);
    check_idle("idle0");

    // ---- Full pass, no stalls: word = page mod 8 ----
    start_pass("p1_start");
    for (int p = 0; p < 32; p++) xfer(p, 3'(p % 8), 1'b0);
    cycle(1'b0, 3'd0, 1'b0);
    check_idle("p1_end");
    check_eq("p1_hold_addr", addr0, 31);
    check_eq("p1_hold_data", data0, 7);

    // ---- Backpressure: valid pattern 1,0,0,1 ----
    start_pass("bp_start");
    page   = 0;
    idx    = 0;
    last_w = 3'd0;
    while (page < 32 && idx < 200) begin
      if ((idx % 4) == 0 || (idx % 4) == 3) begin
        w = 3'((page * 3 + 1) % 8);
        xfer(page, w, 1'b0);
        last_w = w;
        page++;
      end else begin
        cycle(1'b0, 3'd5, 1'b0);
        check_eq("bp_gap_we",    we,        0);
        check_eq("bp_gap_addr0", addr0,     page - 1);
        check_eq("bp_gap_addr1", addr1,     page - 1);
        check_eq("bp_gap_data0", data0,     last_w);
        check_eq("bp_gap_done",  load_done, 0);
        check_eq("bp_gap_busy",  load_busy, 1);
      end
      idx++;
    end
    check_eq("bp_all_pages", page, 32);
    cycle(1'b0, 3'd0, 1'b0);
    check_idle("bp_end");

    // ---- Ignored inputs: valid in IDLE, restart mid-pass, start in DONE ----
    cycle(1'b1, 3'd7, 1'b0);
    check_idle("ign_idle_a");
    check_eq("ign_idle_addr", addr0, 31);
    cycle(1'b1, 3'd7, 1'b0);
    check_idle("ign_idle_b");
    start_pass("ign_start");
    for (int p = 0; p < 32; p++) xfer(p, 3'(7 - (p % 8)), (p == 10) ? 1'b1 : 1'b0);
    // start asserted in the DONE cycle must not keep the loader busy
    cycle(1'b0, 3'd0, 1'b1);
    check_idle("ign_done_start");
    // start now sampled in IDLE and honoured
    cycle(1'b0, 3'd0, 1'b1);
    check_eq("ign_restart_ready", lut_word_ready, 1);
    check_eq("ign_restart_busy",  load_busy,      1);

    // ---- Reset mid-pass after page 15 ----
    for (int p = 0; p < 16; p++) xfer(p, 3'(p % 8), 1'b0);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_data0", data0, 0);
    check_eq("mid_rst_addr0", addr0, 0);
    check_eq("mid_rst_data1", data1, 0);
    check_eq("mid_rst_addr1", addr1, 0);
    check_idle("mid_rst");
    @(negedge write_clk);
    rstn = 1'b1;
    cycle(1'b0, 3'd0, 1'b0);
    check_idle("post_rst");
    start_pass("post_rst_start");
    for (int p = 0; p < 32; p++) xfer(p, 3'((p + 2) % 8), 1'b0);

    // ---- Replica equivalence over two back-to-back random passes ----
    for (int i = 0; i < 64; i++) rnd_words[i] = 3'($urandom_range(0, 7));
    // first cycle is DONE of the previous pass; start held from here on
    cycle(1'b0, 3'd0, 1'b1);
    check_idle("rnd_gap0");
    start_pass("rnd_start_a");
    for (int p = 0; p < 32; p++) xfer(p, rnd_words[p], 1'b0);
    cycle(1'b0, 3'd0, 1'b1);
    check_idle("rnd_gap1");
    start_pass("rnd_start_b");
    for (int p = 0; p < 32; p++) xfer(p, rnd_words[32 + p], 1'b0);
    cycle(1'b0, 3'd0, 1'b0);
    check_idle("rnd_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Replica ports must agree on every cycle, independent of the directed checks
  always @(negedge write_clk) begin
    if (rstn === 1'b1) begin
      check_eq("rep_data_eq", data1, data0);
      check_eq("rep_addr_eq", addr1, addr0);
    end
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule : tb_sym_vn_lut_loader
`default_nettype wire
